// File: rtl/ft601_if.sv
// FT601 245 synchronous-FIFO bridge: TX FIFO bursts host-bound words onto the bus,
// RX FIFO captures device words behind a show-ahead read port.
//
// state  | meaning
// IDLE   | bus released, choosing read (priority) or write
// RD_OE  | device output enable asserted, read strobe still high
// READ   | device drives bus, one word captured per clock
// RD_END | turnaround cycle with bus released
// WRITE  | FPGA drives TX head, one word popped per accepted clock
module ft601_if #(
  parameter int TX_DEPTH = 4096,
  parameter int RX_DEPTH = 1024,
  parameter int BURST    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [31:0] ft601_data,
  inout  wire  [3:0]  ft601_be,
  input  logic        ft601_rxf_n,
  input  logic        ft601_txe_n,
  output logic        ft601_rd_n,
  output logic        ft601_wr_n,
  output logic        ft601_oe_n,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        wr_valid,
  input  logic        wr_push,
  output logic        wr_full,
  output logic [31:0] rd_data,
  output logic [3:0]  rd_be,
  input  logic        rd_en,
  output logic        rd_valid
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int BCW = $clog2(BURST + 1);
  localparam logic [TXW:0] TX_FULL_CNT = (TXW + 1)'(TX_DEPTH);
  localparam logic [TXW:0] TX_BURST    = (TXW + 1)'(BURST);
  localparam logic [RXW:0] RX_FULL_CNT = (RXW + 1)'(RX_DEPTH);
  localparam logic [RXW:0] RX_ROOM4    = (RXW + 1)'(RX_DEPTH - 4);
  localparam logic [RXW:0] RX_ROOM1    = (RXW + 1)'(RX_DEPTH - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);

  typedef enum logic [2:0] {IDLE, RD_OE, READ, RD_END, WRITE} state_t;
  state_t state, state_next;

  logic [35:0]    tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wp, tx_rp;
  logic [TXW:0]   tx_count, tx_count_next;
  logic [35:0]    tx_head;
  logic           tx_wr, tx_rd;

  logic [35:0]    rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wp, rx_rp;
  logic [RXW:0]   rx_count;
  logic [35:0]    rx_head;
  logic           rx_wr, rx_rd, rx_full;

  logic [BCW-1:0] burst_cnt;
  logic           push_pending;
  logic           drive;

  assign wr_full = (tx_count == TX_FULL_CNT);
  assign tx_wr   = wr_valid && !wr_full;
  assign tx_rd   = (state == WRITE) && !ft601_wr_n;
  assign tx_head = tx_mem[tx_rp];
  assign tx_count_next = tx_count + {{TXW{1'b0}}, tx_wr} - {{TXW{1'b0}}, tx_rd};

  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_wr    = (state == READ) && !ft601_rd_n && !ft601_rxf_n;
  assign rx_rd    = rd_en && rd_valid;
  assign rx_head  = rx_mem[rx_rp];
  assign rd_valid = (rx_count != '0);
  assign rd_data  = rx_head[31:0];
  assign rd_be    = rx_head[35:32];

  assign ft601_data = drive ? tx_head[31:0]  : 32'bz;
  assign ft601_be   = drive ? tx_head[35:32] : 4'bz;

  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= {wr_be, wr_data};
    if (rx_wr) rx_mem[rx_wp] <= {ft601_be, ft601_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tx_wp        <= '0;
      tx_rp        <= '0;
      tx_count     <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_count     <= '0;
      burst_cnt    <= '0;
      push_pending <= 1'b0;
    end else begin
      state    <= state_next;
      tx_count <= tx_count_next;
      if (tx_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_rd) tx_rp <= tx_rp + 1'b1;
      if (rx_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_rd) rx_rp <= rx_rp + 1'b1;
      case ({rx_wr, rx_rd})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (state != WRITE) burst_cnt <= '0;
      else if (tx_rd)     burst_cnt <= burst_cnt + 1'b1;
      // A push arriving in the same cycle the FIFO drains must survive.
      if (wr_push)                                      push_pending <= 1'b1;
      else if (state == WRITE && tx_count_next == '0)   push_pending <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    ft601_oe_n = 1'b1;
    ft601_rd_n = 1'b1;
    ft601_wr_n = 1'b1;
    drive      = 1'b0;
    case (state)
      IDLE: begin
        if (!ft601_rxf_n && rx_count <= RX_ROOM4)
          state_next = RD_OE;
        else if (!ft601_txe_n && tx_count != '0 && (tx_count >= TX_BURST || push_pending))
          state_next = WRITE;
      end
      RD_OE: begin
        ft601_oe_n = 1'b0;
        state_next = READ;
      end
      READ: begin
        ft601_oe_n = 1'b0;
        ft601_rd_n = rx_full;
        if (ft601_rxf_n || rx_count >= RX_ROOM1) state_next = RD_END;
      end
      RD_END: state_next = IDLE;
      WRITE: begin
        drive      = 1'b1;
        ft601_wr_n = !(tx_count != '0 && !ft601_txe_n);
        if (ft601_txe_n || tx_count == '0 || (!ft601_wr_n && burst_cnt == BURST_LAST))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft601_if.sv
// Bench for ft601_if: behavioural FT601 device, scoreboard queues for both directions,
// monitors comparing each word as it crosses the interface.
module tb_ft601_if;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [31:0] ft601_data;
  wire  [3:0]  ft601_be;
  logic        ft601_rxf_n = 1'b1;
  logic        ft601_txe_n = 1'b1;
  logic        ft601_rd_n, ft601_wr_n, ft601_oe_n;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        wr_valid = 1'b0;
  logic        wr_push = 1'b0;
  logic        wr_full;
  logic [31:0] rd_data;
  logic [3:0]  rd_be;
  logic        rd_en = 1'b0;
  logic        rd_valid;

  logic [31:0] dev_data = '0;
  logic [3:0]  dev_be = '0;
  assign ft601_data = !ft601_oe_n ? dev_data : 32'bz;
  assign ft601_be   = !ft601_oe_n ? dev_be   : 4'bz;

  ft601_if dut (
    .clk(clk), .reset(reset),
    .ft601_data(ft601_data), .ft601_be(ft601_be),
    .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .ft601_rd_n(ft601_rd_n), .ft601_wr_n(ft601_wr_n), .ft601_oe_n(ft601_oe_n),
    .wr_data(wr_data), .wr_be(wr_be), .wr_valid(wr_valid), .wr_push(wr_push),
    .wr_full(wr_full), .rd_data(rd_data), .rd_be(rd_be), .rd_en(rd_en),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [35:0] tx_q[$];
  logic [35:0] rx_q[$];
  int tx_sent = 0;
  int rx_got = 0;
  int rx_idx = 0;
  int rx_total = 0;
  int mode = 0;            // 0: txe_n high, 1: accept, 2: accept with periodic stalls
  int last_oe_cyc = -100;
  int first_wr_cyc = -1;
  bit arm_first = 1'b0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Device side of the TX path: consumes words on wr_n low and owns txe_n.
  initial begin
    int since = 0;
    int stall = 0;
    logic [35:0] exp;
    forever begin
      @(negedge clk);
      if (!ft601_oe_n) begin
        check("no_write_during_oe", 36'(ft601_wr_n), 36'(1));
        last_oe_cyc = cyc;
      end
      if (!ft601_wr_n) begin
        tx_sent++;
        since++;
        if (arm_first && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_extra: got %h expected none", {ft601_be, ft601_data});
        end else begin
          exp = tx_q.pop_front();
          check("tx_word", {ft601_be, ft601_data}, exp);
        end
      end
      @(posedge clk); #2;
      if (mode == 2 && since >= 64) begin stall = 5; since = 0; end
      if (stall > 0) begin ft601_txe_n = 1'b1; stall--; end
      else ft601_txe_n = (mode == 0);
    end
  end

  // Device side of the RX path plus the rd_en monitor.
  initial begin
    logic prev_oe = 1'b1;
    logic prev_rd = 1'b1;
    int oe_fall = -100;
    logic [35:0] exp;
    forever begin
      @(negedge clk);
      if (!ft601_rd_n && !ft601_rxf_n) begin
        rx_q.push_back({dev_be, dev_data});
        rx_idx++;
      end
      if (!ft601_oe_n && prev_oe) oe_fall = cyc;
      if (!ft601_rd_n && prev_rd) check("oe_leads_rd", 36'(cyc - oe_fall), 36'(1));
      prev_oe = ft601_oe_n;
      prev_rd = ft601_rd_n;
      if (rd_en && rd_valid) begin
        rx_got++;
        if (rx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_extra: got %h expected none", {rd_be, rd_data});
        end else begin
          exp = rx_q.pop_front();
          check("rx_word", {rd_be, rd_data}, exp);
        end
      end
      @(posedge clk); #2;
      ft601_rxf_n = !(rx_idx < rx_total);
      dev_data = 32'hA500_0000 + 32'(rx_idx);
      dev_be = 4'(rx_idx) ^ 4'hF;
    end
  end

  task automatic send_words(input int n, input logic [31:0] base, input bit rot,
                            input bit flow, output int stalls);
    int j = 0;
    int guard = 0;
    stalls = 0;
    while (j < n && guard < n * 2 + 8000) begin
      @(posedge clk); #1;
      guard++;
      if (!wr_full) begin
        wr_valid = 1'b1;
        wr_data = base + 32'(j);
        wr_be = rot ? 4'(1 << (j % 4)) : 4'hF;
        tx_q.push_back({wr_be, wr_data});
        j++;
      end else begin
        wr_valid = 1'b0;
        stalls++;
        if (flow) mode = 2;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("send_complete", 36'(j), 36'(n));
  endtask

  task automatic pulse_push();
    wr_push = 1'b1;
    @(posedge clk); #1;
    wr_push = 1'b0;
  endtask

  task automatic wait_tx_empty(input int limit);
    int k = 0;
    while (tx_q.size() != 0 && k < limit) begin @(posedge clk); #1; k++; end
    check("tx_drained_left", 36'(tx_q.size()), 36'(0));
  endtask

  task automatic wait_rx(input int target, input int limit);
    int k = 0;
    while (rx_got < target && k < limit) begin @(posedge clk); #1; k++; end
    check("rx_count", 36'(rx_got), 36'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_n"}, 36'(ft601_rd_n), 36'(1));
    check({tag, "_wr_n"}, 36'(ft601_wr_n), 36'(1));
    check({tag, "_oe_n"}, 36'(ft601_oe_n), 36'(1));
    check({tag, "_wr_full"}, 36'(wr_full), 36'(0));
    check({tag, "_rd_valid"}, 36'(rd_valid), 36'(0));
  endtask

  initial begin
    int base;
    int st;
    int k;

    // Reset held 100 cycles with device idle.
    repeat (100) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Streaming TX with a continuously accepting device.
    mode = 1;
    base = tx_sent;
    send_words(8192, 32'h0, 1'b1, 1'b0, st);
    pulse_push();
    wait_tx_empty(20000);
    check("stream_sent", 36'(tx_sent - base), 36'(8192));

    // Sub-burst: nothing moves until push; push_pending clears after the flush.
    base = tx_sent;
    send_words(1000, 32'h1000_0000, 1'b0, 1'b0, st);
    repeat (50) @(posedge clk);
    #1;
    check("subburst_no_send", 36'(tx_sent - base), 36'(0));
    pulse_push();
    wait_tx_empty(3000);
    repeat (5) @(posedge clk);
    #1;
    check("subburst_sent", 36'(tx_sent - base), 36'(1000));
    check("subburst_wr_n_idle", 36'(ft601_wr_n), 36'(1));
    send_words(10, 32'h2000_0000, 1'b0, 1'b0, st);
    repeat (50) @(posedge clk);
    #1;
    check("push_cleared", 36'(tx_sent - base), 36'(1000));
    pulse_push();
    wait_tx_empty(500);
    check("tail_sent", 36'(tx_sent - base), 36'(1010));

    // Fill the TX FIFO with the device blocked; the extra word is dropped.
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    base = tx_sent;
    for (int i = 0; i < 4096; i++) begin
      if (i == 4095) check("not_full_at_4095", 36'(wr_full), 36'(0));
      wr_valid = 1'b1;
      wr_data = 32'h3000_0000 + 32'(i);
      wr_be = 4'(i);
      tx_q.push_back({wr_be, wr_data});
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("full_after_4096", 36'(wr_full), 36'(1));
    wr_valid = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    wr_be = 4'hF;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("full_after_drop", 36'(wr_full), 36'(1));
    mode = 1;
    wait_tx_empty(10000);
    repeat (10) @(posedge clk);
    #1;
    check("full_drain_sent", 36'(tx_sent - base), 36'(4096));
    check("full_cleared", 36'(wr_full), 36'(0));

    // Flow control: fill against a blocked device, then stall 5 cycles every 64 words.
    mode = 0;
    base = tx_sent;
    send_words(8192, 32'h5000_0000, 1'b0, 1'b1, st);
    check("flow_source_stalled", 36'(st > 0), 36'(1));
    check("flow_mode_engaged", 36'(mode), 36'(2));
    pulse_push();
    wait_tx_empty(20000);
    check("flow_sent", 36'(tx_sent - base), 36'(8192));
    mode = 0;

    // RX: 16 words buffered, then drained through the show-ahead port.
    base = rx_got;
    rx_total = rx_total + 16;
    k = 0;
    while (rx_idx < rx_total && k < 200) begin @(posedge clk); #1; k++; end
    repeat (5) @(posedge clk);
    #1;
    check("rx_valid_before_drain", 36'(rd_valid), 36'(1));
    check("rx_head", {rd_be, rd_data}, {4'h0 ^ 4'hF, 32'hA500_0000});
    rd_en = 1'b1;
    wait_rx(base + 16, 100);
    repeat (3) @(posedge clk);
    #1;
    rd_en = 1'b0;
    check("rx_empty_after_drain", 36'(rd_valid), 36'(0));

    // RX with rd_en held, so pushes and pops overlap.
    base = rx_got;
    rd_en = 1'b1;
    rx_total = rx_total + 16;
    wait_rx(base + 16, 200);
    rd_en = 1'b0;

    // Contention: full burst pending while the device also has read data.
    base = tx_sent;
    send_words(1024, 32'h6000_0000, 1'b1, 1'b0, st);
    repeat (10) @(posedge clk);
    #1;
    check("contend_no_early_write", 36'(tx_sent - base), 36'(0));
    arm_first = 1'b1;
    first_wr_cyc = -1;
    rd_en = 1'b1;
    base = rx_got;
    rx_total = rx_total + 16;
    mode = 1;
    wait_rx(base + 16, 300);
    wait_tx_empty(3000);
    rd_en = 1'b0;
    arm_first = 1'b0;
    check("read_to_write_gap", 36'(first_wr_cyc - last_oe_cyc), 36'(3));

    // Reset in the middle of a write burst with unread RX data.
    mode = 0;
    rx_total = rx_total + 4;
    k = 0;
    while (rx_idx < rx_total && k < 200) begin @(posedge clk); #1; k++; end
    send_words(2000, 32'h7000_0000, 1'b0, 1'b0, st);
    check("pre_reset_rd_valid", 36'(rd_valid), 36'(1));
    mode = 1;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    tx_q.delete();
    rx_q.delete();
    reset = 1'b0;
    base = tx_sent;
    repeat (30) @(posedge clk);
    #1;
    check("post_reset_no_send", 36'(tx_sent - base), 36'(0));
    pulse_push();
    repeat (30) @(posedge clk);
    #1;
    check("post_reset_push_empty", 36'(tx_sent - base), 36'(0));
    check("post_reset_rd_valid", 36'(rd_valid), 36'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
